// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises LSB loads/stores and instruction fetches into byte accesses on the 8-bit RAM port.
// Define MEM_CTRL_IO_STALL_EN to hold IO-region writes (mem_a[17:16]==2'b11) while io_buffer_full is set.
module mem_ctrl (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        rdy_in,
    input  logic        activate_cache,
    input  logic [31:0] ls_addr,
    input  logic        r_nw_out,
    input  logic [2:0]  type_out,
    input  logic [31:0] st_val,
    output logic [31:0] ld_val,
    output logic        ls_done_in,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_data,
    output logic        if_done,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    input  logic        io_buffer_full
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;
    typedef enum logic {OWN_DATA, OWN_FETCH} owner_t;

    state_t      r_state;
    state_t      w_nextState;
    owner_t      r_owner;
    logic [31:0] r_base;
    logic [31:0] r_stVal;
    logic [31:0] r_data;
    logic [2:0]  r_type;
    logic        r_isRead;
    logic [2:0]  r_cnt;

    logic [2:0]  w_numBytes;
    logic [2:0]  w_presIdx;
    logic [1:0]  w_capIdx;
    logic [31:0] w_byteAddr;
    logic [31:0] w_ext;
    logic        w_advance;
    logic        w_capture;
    logic        w_ioStall;

    always_comb begin
        case (r_type[1:0])
            2'b01:   w_numBytes = 3'd2;
            2'b10:   w_numBytes = 3'd1;
            default: w_numBytes = 3'd4;
        endcase
    end

    // While frozen mid-read, re-present the address whose byte is still awaiting capture.
    assign w_presIdx  = (r_state == READ && !rdy_in && r_cnt != 3'd0) ? r_cnt - 3'd1 : r_cnt;
    assign w_capIdx   = 2'(r_cnt - 3'd1);
    assign w_byteAddr = r_base + {29'd0, w_presIdx};

`ifdef MEM_CTRL_IO_STALL_EN
    assign w_ioStall = (w_byteAddr[17:16] == 2'b11) && io_buffer_full;
`else
    logic w_unusedIoFull;
    assign w_unusedIoFull = io_buffer_full;
    assign w_ioStall      = 1'b0;
`endif

    always_comb begin
        case (r_type[1:0])
            2'b10:   w_ext = {{24{r_type[2] & r_data[7]}}, r_data[7:0]};
            2'b01:   w_ext = {{16{r_type[2] & r_data[15]}}, r_data[15:0]};
            default: w_ext = r_data;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        w_advance   = 1'b0;
        w_capture   = 1'b0;
        mem_a       = '0;
        mem_dout    = '0;
        mem_wr      = 1'b0;
        ld_val      = '0;
        ls_done_in  = 1'b0;
        if_data     = '0;
        if_done     = 1'b0;
        case (r_state)
            IDLE: begin
                if (rdy_in) begin
                    if (activate_cache) begin
                        w_nextState = r_nw_out ? READ : WRITE;
                    end else if (if_req) begin
                        w_nextState = READ;
                    end
                end
            end
            READ: begin
                if (w_presIdx < w_numBytes) begin
                    mem_a = w_byteAddr;
                end
                if (rdy_in) begin
                    w_capture = (r_cnt != 3'd0);
                    if (r_cnt == w_numBytes) begin
                        w_nextState = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            WRITE: begin
                mem_a = w_byteAddr;
                case (r_cnt[1:0])
                    2'd0:    mem_dout = r_stVal[7:0];
                    2'd1:    mem_dout = r_stVal[15:8];
                    2'd2:    mem_dout = r_stVal[23:16];
                    default: mem_dout = r_stVal[31:24];
                endcase
                if (rdy_in && !w_ioStall) begin
                    mem_wr = 1'b1;
                    if (r_cnt == w_numBytes - 3'd1) begin
                        w_nextState = DONE;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            DONE: begin
                if (rdy_in) begin
                    w_nextState = IDLE;
                    if (r_owner == OWN_FETCH) begin
                        if_done = 1'b1;
                        if_data = r_data;
                    end else begin
                        ls_done_in = 1'b1;
                        ld_val     = r_isRead ? w_ext : '0;
                    end
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Request latch on accept; byte counter and capture buffer advance only while ready.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_owner  <= OWN_DATA;
            r_base   <= '0;
            r_stVal  <= '0;
            r_data   <= '0;
            r_type   <= '0;
            r_isRead <= 1'b0;
            r_cnt    <= '0;
        end else if (rdy_in) begin
            if (r_state == IDLE) begin
                r_cnt  <= '0;
                r_data <= '0;
                if (activate_cache) begin
                    r_owner  <= OWN_DATA;
                    r_base   <= ls_addr;
                    r_type   <= type_out;
                    r_isRead <= r_nw_out;
                    r_stVal  <= st_val;
                end else if (if_req) begin
                    r_owner  <= OWN_FETCH;
                    r_base   <= if_addr;
                    r_type   <= 3'b000;
                    r_isRead <= 1'b1;
                end
            end else begin
                if (w_advance) begin
                    r_cnt <= r_cnt + 3'd1;
                end
                if (w_capture) begin
                    r_data[{w_capIdx, 3'b000} +: 8] <= mem_din;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_ctrl.sv
// tb_mem_ctrl: randomized and directed checks of mem_ctrl against a transaction-level model with a byte RAM.
// Build with MEM_CTRL_IO_STALL_EN defined to expect IO write stalling.
module tb_mem_ctrl;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        activate_cache;
    logic [31:0] ls_addr;
    logic        r_nw_out;
    logic [2:0]  type_out;
    logic [31:0] st_val;
    logic [31:0] ld_val;
    logic        ls_done_in;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_data;
    logic        if_done;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full;

    mem_ctrl dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .rdy_in         (rdy_in),
        .activate_cache (activate_cache),
        .ls_addr        (ls_addr),
        .r_nw_out       (r_nw_out),
        .type_out       (type_out),
        .st_val         (st_val),
        .ld_val         (ld_val),
        .ls_done_in     (ls_done_in),
        .if_req         (if_req),
        .if_addr        (if_addr),
        .if_data        (if_data),
        .if_done        (if_done),
        .mem_din        (mem_din),
        .mem_dout       (mem_dout),
        .mem_a          (mem_a),
        .mem_wr         (mem_wr),
        .io_buffer_full (io_buffer_full)
    );

    always #5 clk_in = ~clk_in;

    typedef struct packed {
        logic [31:0] a;
        logic [7:0]  d;
    } wrRec_t;

    int          total = 0;
    int          bad   = 0;
    logic [7:0]  ramOvr [logic [31:0]];
    wrRec_t      wrLog [$];
    logic        obsLdDone;
    logic        obsIfDone;
    logic        obsWr;
    logic [31:0] obsLd;
    logic [31:0] obsIf;
    logic [31:0] obsA;

`ifdef MEM_CTRL_IO_STALL_EN
    localparam int IoStoreLat = 5;
`else
    localparam int IoStoreLat = 2;
`endif

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, want);
        end
    endtask

    function automatic logic [7:0] ramRead(input logic [31:0] a);
        if (ramOvr.exists(a)) return ramOvr[a];
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'h5C;
    endfunction

    function automatic int numBytes(input logic [2:0] t);
        case (t[1:0])
            2'b01:   return 2;
            2'b10:   return 1;
            default: return 4;
        endcase
    endfunction

    // Little-endian assembly of n bytes, then sign or zero extension of the narrow value.
    function automatic logic [31:0] modelLoad(input logic [2:0] t, input logic [31:0] a);
        logic [31:0] raw;
        int          n;
        raw = '0;
        n   = numBytes(t);
        for (int k = 0; k < n; k++) raw = raw | (32'(ramRead(a + 32'(k))) << (8 * k));
        if (n < 4 && t[2] && raw[8 * n - 1]) raw = raw | (32'hFFFF_FFFF << (8 * n));
        return raw;
    endfunction

    // Sample this cycle at the falling edge, then feed the RAM byte for this cycle's address.
    task automatic stepCycle();
        @(negedge clk_in);
        obsLdDone = ls_done_in;
        obsIfDone = if_done;
        obsLd     = ld_val;
        obsIf     = if_data;
        obsWr     = mem_wr;
        obsA      = mem_a;
        if (!obsLdDone) checkOutput("ldZero", ld_val, 32'h0);
        if (!rdy_in) checkOutput("wrFrozen", {31'b0, mem_wr}, 32'h0);
        if (obsWr) begin
            wrLog.push_back({mem_a, mem_dout});
            ramOvr[mem_a] = mem_dout;
        end
        @(posedge clk_in);
        #1;
        mem_din = ramRead(obsA);
    endtask

    task automatic checkIdle(input string tag, input int cycles);
        for (int c = 0; c < cycles; c++) begin
            stepCycle();
            checkOutput({tag, "_a"}, obsA, 32'h0);
            checkOutput({tag, "_wr"}, {31'b0, obsWr}, 32'h0);
            checkOutput({tag, "_done"}, {30'b0, obsLdDone, obsIfDone}, 32'h0);
        end
    endtask

    // One request from accept (cycle 0) to its done pulse; expLat<0 means latency counted in ready cycles.
    task automatic applyStimulus(input string tag, input bit isFetch, input bit keepFetch,
                                 input bit rnw, input logic [2:0] typ, input logic [31:0] addr,
                                 input logic [31:0] stv, input int rdyPct, input logic [15:0] lowMask,
                                 input int ioFullCyc, input int expLat);
        int          n;
        int          baseLat;
        int          readyCnt;
        int          doneCyc;
        bit          isRead;
        logic [31:0] expVal;
        isRead  = isFetch || rnw;
        n       = isFetch ? 4 : numBytes(typ);
        baseLat = isRead ? n + 2 : n + 1;
        expVal  = isFetch ? modelLoad(3'b000, addr) : modelLoad(typ, addr);
        activate_cache = !isFetch;
        if_req         = isFetch || keepFetch;
        if (isFetch) if_addr = addr;
        else begin
            ls_addr  = addr;
            r_nw_out = rnw;
            type_out = typ;
            st_val   = stv;
        end
        rdy_in         = 1'b1;
        io_buffer_full = (ioFullCyc > 0);
        wrLog.delete();
        readyCnt = 0;
        doneCyc  = -1;
        for (int cyc = 0; cyc < 80 && doneCyc < 0; cyc++) begin
            if (cyc > 0 && rdy_in) readyCnt++;
            stepCycle();
            if (obsLdDone || obsIfDone) begin
                doneCyc = cyc;
            end else begin
                rdy_in = !(((cyc + 1) < 16 && lowMask[cyc + 1]) || ($urandom_range(99) < 32'(rdyPct)));
                io_buffer_full = (ioFullCyc < 0) ? 1'($urandom_range(1)) : ((cyc + 1) <= ioFullCyc);
            end
        end
        if (doneCyc < 0) begin
            checkOutput({tag, "_timeout"}, 32'h0, 32'h1);
        end else begin
            checkOutput({tag, "_owner"}, {30'b0, obsLdDone, obsIfDone}, isFetch ? 32'h1 : 32'h2);
            if (expLat >= 0) checkOutput({tag, "_lat"}, 32'(doneCyc), 32'(expLat));
            else checkOutput({tag, "_lat"}, 32'(readyCnt), 32'(baseLat));
            if (isRead) checkOutput({tag, "_data"}, isFetch ? obsIf : obsLd, expVal);
        end
        checkOutput({tag, "_nwr"}, 32'(wrLog.size()), isRead ? 32'h0 : 32'(n));
        for (int k = 0; k < wrLog.size() && k < n; k++) begin
            checkOutput({tag, "_wa"}, wrLog[k].a, addr + 32'(k));
            checkOutput({tag, "_wd"}, 32'(wrLog[k].d), 32'(stv[8 * k +: 8]));
        end
        activate_cache = 1'b0;
        if_req         = keepFetch;
        rdy_in         = 1'b1;
        io_buffer_full = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_in         = 1'b1;
        rdy_in         = 1'b1;
        activate_cache = 1'b0;
        if_req         = 1'b0;
        ls_addr        = '0;
        if_addr        = '0;
        r_nw_out       = 1'b1;
        type_out       = 3'b000;
        st_val         = '0;
        mem_din        = '0;
        io_buffer_full = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        checkOutput("rst_ld", ld_val, 32'h0);
        checkOutput("rst_if", if_data, 32'h0);
        checkOutput("rst_ldDone", {31'b0, ls_done_in}, 32'h0);
        checkOutput("rst_ifDone", {31'b0, if_done}, 32'h0);
        checkOutput("rst_a", mem_a, 32'h0);
        checkOutput("rst_dout", {24'b0, mem_dout}, 32'h0);
        checkOutput("rst_wr", {31'b0, mem_wr}, 32'h0);
        rst_in = 1'b0;

        ramOvr[32'h1000] = 8'h11;
        ramOvr[32'h1001] = 8'h22;
        ramOvr[32'h1002] = 8'h33;
        ramOvr[32'h1003] = 8'h44;
        ramOvr[32'h2003] = 8'h80;
        ramOvr[32'h2010] = 8'h01;
        ramOvr[32'h2011] = 8'h80;

        applyStimulus("lw", 0, 0, 1, 3'b000, 32'h1000, 0, 0, 16'h0, 0, 6);
        checkOutput("lw_val", obsLd, 32'h4433_2211);
        applyStimulus("lb", 0, 0, 1, 3'b110, 32'h2003, 0, 0, 16'h0, 0, 3);
        checkOutput("lb_val", obsLd, 32'hFFFF_FF80);
        applyStimulus("lbu", 0, 0, 1, 3'b010, 32'h2003, 0, 0, 16'h0, 0, 3);
        checkOutput("lbu_val", obsLd, 32'h0000_0080);
        applyStimulus("lh", 0, 0, 1, 3'b101, 32'h2010, 0, 0, 16'h0, 0, 4);
        checkOutput("lh_val", obsLd, 32'hFFFF_8001);
        applyStimulus("sh", 0, 0, 0, 3'b001, 32'h3000, 32'hDEAD_BEEF, 0, 16'h0, 0, 3);
        applyStimulus("lhu", 0, 0, 1, 3'b001, 32'h3000, 0, 0, 16'h0, 0, 4);
        checkOutput("lhu_val", obsLd, 32'h0000_BEEF);
        applyStimulus("sw", 0, 0, 0, 3'b000, 32'h3100, 32'hCAFE_F00D, 0, 16'h0, 0, 5);
        applyStimulus("lwWrap", 0, 0, 1, 3'b000, 32'hFFFF_FFFE, 0, 0, 16'h0, 0, 6);
        checkIdle("idle1", 2);

        if_addr = 32'h5000;
        applyStimulus("tieData", 0, 1, 1, 3'b001, 32'h4000, 0, 0, 16'h0, 0, 4);
        applyStimulus("tieFetch", 1, 0, 1, 3'b000, 32'h5000, 0, 0, 16'h0, 0, 6);
        checkIdle("idle2", 2);

        applyStimulus("sbIo", 0, 0, 0, 3'b010, 32'h0003_0000, 32'h0000_005A, 0, 16'h0, 3, IoStoreLat);
        applyStimulus("lwFreeze", 0, 0, 1, 3'b000, 32'h1000, 0, 0, 16'h0018, 0, 8);
        checkOutput("lwFreeze_val", obsLd, 32'h4433_2211);
        checkIdle("idle3", 1);

        ls_addr        = 32'h1000;
        r_nw_out       = 1'b1;
        type_out       = 3'b000;
        activate_cache = 1'b1;
        stepCycle();
        stepCycle();
        checkOutput("rstMid_preA", mem_a, 32'h1001);
        rst_in = 1'b1;
        #1;
        checkOutput("rstMid_a", mem_a, 32'h0);
        checkOutput("rstMid_wr", {31'b0, mem_wr}, 32'h0);
        checkOutput("rstMid_done", {30'b0, ls_done_in, if_done}, 32'h0);
        checkOutput("rstMid_ld", ld_val, 32'h0);
        activate_cache = 1'b0;
        stepCycle();
        stepCycle();
        rst_in = 1'b0;
        checkIdle("rstIdle", 6);
        applyStimulus("lwAfterRst", 0, 0, 1, 3'b000, 32'h1000, 0, 0, 16'h0, 0, 6);
        checkOutput("lwAfterRst_val", obsLd, 32'h4433_2211);

        for (int i = 0; i < 40; i++) begin
            bit          f;
            bit          rnw;
            logic [2:0]  t;
            logic [31:0] a;
            f    = ($urandom_range(3) == 0);
            rnw  = 1'($urandom_range(1));
            t    = {1'($urandom_range(1)), 2'($urandom_range(2))};
            a    = 32'h0001_0000 + 32'($urandom_range(63));
            applyStimulus($sformatf("rnd%0d", i), f, 0, rnw, t, a, $urandom, 20, 16'h0, -1, -1);
        end
        checkIdle("idleEnd", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Responder side of the load/store request interface: accepts one load or store at a time from the load-store buffer, plus instruction-fetch word reads, and serialises each into byte transactions on the 8-bit external RAM port. It sits between the load-store buffer / fetch unit and the RAM/IO bus. It returns a one-cycle done pulse with sign- or zero-extended load data.

## Interface
- No parameters.
- clk_in  input  1  clock; all state on rising edge.
- rst_in  input  1  reset, asynchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state.
- activate_cache  input  1  LSB request, level, held until ls_done_in.
- ls_addr  input  32  byte address of data access.
- r_nw_out  input  1  1 read, 0 write.
- type_out  input  3  [1:0] 00 word / 01 half / 10 byte; [2] 1 signed (loads only).
- st_val  input  32  store data, low bytes used.
- ld_val  output  32  extended load data, valid only with ls_done_in.
- ls_done_in  output  1  one-cycle completion pulse to LSB.
- if_req  input  1  fetch request, level, held until if_done.
- if_addr  input  32  fetch word address.
- if_data  output  32  fetched word, valid with if_done.
- if_done  output  1  one-cycle fetch completion pulse.
- mem_din  input  8  RAM read byte, for the address presented the previous cycle.
- mem_dout  output  8  RAM write byte.
- mem_a  output  32  RAM byte address.
- mem_wr  output  1  1 write, 0 read.
- io_buffer_full  input  1  IO write sink full.

## Operation
- States: IDLE, READ, WRITE, DONE.
- IDLE: if activate_cache, latch addr/type/r_nw/st_val and owner=DATA. Else if if_req, latch if_addr, type word, read, owner=FETCH. Data wins ties.
- Byte count N: 4 word, 2 half, 1 byte. Byte k at address base+k, little-endian; 32-bit wrapping add.
- READ: cycles 1..N present mem_a=base+k, mem_wr=0. Capture mem_din into byte k one cycle later. After the last capture, go to DONE.
- WRITE: cycles 1..N present mem_a=base+k, mem_wr=1, mem_dout=st_val byte k. Then go to DONE.
- DONE: pulse ls_done_in or if_done for the owner for exactly one cycle, with ld_val/if_data valid. Return to IDLE.
- A new request is never accepted in the DONE cycle. The earliest accept is the cycle after DONE, so a still-asserted activate_cache for the retiring entry is never re-serviced.
- Load extension: byte and half are sign-extended when type[2]=1, zero-extended otherwise. Word is passed through. ld_val=0 outside DONE.
- Outside READ/WRITE: mem_wr=0, mem_a=0, mem_dout=0.

## Timing
- Accept cycle = cycle 0, in IDLE.
- Load latency N+2: done in cycle 3 for byte, 4 for half, 6 for word.
- Store latency N+1: done in cycle 2 for byte, 3 for half, 5 for word.
- Fetch latency 6, same as a word load.
- Back-to-back throughput: one request per latency+1 cycles.
- rdy_in low: state, counters and captured bytes hold; mem_wr forced 0. A read byte whose capture cycle is frozen is re-fetched by re-presenting the same address after rdy_in returns.
- Reset, any time: state IDLE, in-flight request dropped without a done pulse.
- Reset values: all outputs 0, including ld_val, if_data, ls_done_in, if_done, mem_a, mem_dout and mem_wr.

## Configuration
- MEM_CTRL_IO_STALL_EN defined:
  - A write byte with mem_a[17:16]==2'b11 while io_buffer_full=1 is held: mem_wr=0, byte counter holds.
  - The byte issues on the first cycle io_buffer_full=0.
  - Store latency grows by the stall cycles.
- Undefined: io_buffer_full is ignored and IO writes issue without stalling.

## Test plan
- LW at 0x1000, RAM bytes 11,22,33,44 -> mem_a 0x1000..0x1003 in cycles 1-4; ls_done_in in cycle 6 only; ld_val=0x44332211.
- LB signed at 0x2003 holding 0x80 -> done cycle 3, ld_val=0xFFFFFF80. Repeat as LBU -> 0x00000080. LH signed holding 0x8001 -> 0xFFFF8001.
- SH st_val=0xDEADBEEF to 0x3000 -> mem_wr=1 cycles 1-2; mem_a/mem_dout 0x3000/EF then 0x3001/BE; done cycle 3.
- activate_cache and if_req both high in IDLE -> data serviced first. Fetch accepted the cycle after ls_done_in; if_done 6 cycles later. activate_cache held through DONE is not re-accepted.
- SB to 0x30000 with io_buffer_full high for 3 cycles -> with MEM_CTRL_IO_STALL_EN: mem_wr=0 for 3 cycles, then write; done cycle 5. Without the macro: done cycle 2.
- rst_in asserted in cycle 2 of an LW -> all outputs 0 immediately; no done pulse; a new LW after release completes in 6 cycles. rdy_in low for 2 cycles mid-LW -> done at cycle 8 with correct data.
